// File: rtl/uart_sort_pkg.sv
// uart_sort_pkg: FSM states, frame header codes and frame sizing shared by uart_frame_sorter
package uart_sort_pkg;
  typedef enum logic [2:0] {IDLE, RECV, SORT, SEND, WAIT_TX} state_t;
  localparam logic [7:0] HDR_ASC  = 8'hA5;
  localparam logic [7:0] HDR_DESC = 8'h5A;
  function automatic int nbytes(input int depth, input int width);
    return depth * width / 8;
  endfunction
endpackage

// File: rtl/sort_cmp_swap.sv
// sort_cmp_swap: unsigned compare-and-swap of one adjacent element pair; equal values never swap
module sort_cmp_swap #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             desc,
  output logic [WIDTH-1:0] y0,
  output logic [WIDTH-1:0] y1
);
  logic swap;
  // swap only when the pair is strictly out of order for the requested direction
  always_comb begin
    swap = desc ? (a < b) : (a > b);
    y0 = swap ? b : a;
    y1 = swap ? a : b;
  end
endmodule

// File: rtl/uart_frame_sorter.sv
// uart_frame_sorter: receives a headered UART frame of DEPTH elements, sorts it and retransmits it.
// Optional feature: define UART_SORT_CHECKSUM_EN for a trailing XOR checksum byte on input and output.
module uart_frame_sorter
  import uart_sort_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int DEPTH       = 8,
  parameter int TIMEOUT_CYC = 1_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  input  logic        tx_busy,
  output logic [7:0]  tx_data,
  output logic        tx_start,
  output logic        busy,
  output logic        frame_err,
  output logic [15:0] frame_count
);
  localparam int NB   = nbytes(DEPTH, WIDTH);
  localparam int BITS = DEPTH * WIDTH;
`ifdef UART_SORT_CHECKSUM_EN
  localparam int LEN = NB + 1;
`else
  localparam int LEN = NB;
`endif
  localparam int CW = $clog2(LEN + 1);
  localparam int PW = $clog2(DEPTH + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  // element k lives at mem[(DEPTH-1-k)*WIDTH +: WIDTH], so the frame shifts in and out at the top byte
  state_t                      state_q, state_d;
  logic [BITS-1:0]             mem_q, mem_d, net;
  logic [CW-1:0]               cnt_q, cnt_d;
  logic [PW-1:0]               pass_q, pass_d;
  logic [TW-1:0]               tmo_q, tmo_d;
  logic                        desc_q, desc_d;
  logic                        first_q, first_d;
  logic                        err_q, err_d;
  logic [15:0]                 fcnt_q, fcnt_d;
  logic [DEPTH-2:0][WIDTH-1:0] y0, y1;
  logic [7:0]                  byte_out;
  logic                        cs_ok;

  for (genvar g = 0; g < DEPTH - 1; g++) begin : g_pair
    sort_cmp_swap #(.WIDTH(WIDTH)) u_cmp (
      .a    (mem_q[(DEPTH-1-g)*WIDTH +: WIDTH]),
      .b    (mem_q[(DEPTH-2-g)*WIDTH +: WIDTH]),
      .desc (desc_q),
      .y0   (y0[g]),
      .y1   (y1[g])
    );
  end

  // one transposition pass: even passes take pairs starting on even elements, odd passes on odd ones
  always_comb begin
    net = mem_q;
    for (int k = 0; k < DEPTH - 1; k++)
      if ((k % 2) == int'(pass_q[0])) begin
        net[(DEPTH-1-k)*WIDTH +: WIDTH] = y0[k];
        net[(DEPTH-2-k)*WIDTH +: WIDTH] = y1[k];
      end
  end

`ifdef UART_SORT_CHECKSUM_EN
  logic [7:0] csum_q, csum_d;
  assign cs_ok    = rx_data == csum_q;
  assign byte_out = (cnt_q < CW'(NB)) ? mem_q[BITS-1 -: 8] : csum_q;
  // running XOR: header and data while receiving, transmitted data bytes while sending
  always_comb begin
    csum_d = csum_q;
    if (state_q == IDLE) csum_d = rx_data;
    else if (state_q == RECV && rx_valid) csum_d = (cnt_q == CW'(LEN - 1)) ? 8'h00 : csum_q ^ rx_data;
    else if (tx_start) csum_d = csum_q ^ tx_data;
  end
  // checksum register
  always_ff @(posedge clk or posedge rst)
    if (rst) csum_q <= 8'h00;
    else csum_q <= csum_d;
`else
  assign cs_ok    = 1'b1;
  assign byte_out = mem_q[BITS-1 -: 8];
`endif

  // frame FSM: receive, sort in place, then hand bytes to the transmitter one at a time
  always_comb begin
    state_d  = state_q;
    mem_d    = mem_q;
    cnt_d    = cnt_q;
    pass_d   = pass_q;
    tmo_d    = tmo_q;
    desc_d   = desc_q;
    first_d  = 1'b0;
    fcnt_d   = fcnt_q;
    err_d    = rx_valid && (state_q == SORT || state_q == SEND || state_q == WAIT_TX);
    tx_start = 1'b0;
    tx_data  = 8'h00;
    case (state_q)
      IDLE:
        if (rx_valid && (rx_data == HDR_ASC || rx_data == HDR_DESC)) begin
          state_d = RECV;
          desc_d  = rx_data == HDR_DESC;
          cnt_d   = '0;
          tmo_d   = '0;
        end
      RECV:
        if (rx_valid) begin
          tmo_d = '0;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q < CW'(NB)) mem_d = {mem_q[BITS-9:0], rx_data};
          if (cnt_q == CW'(LEN - 1)) begin
            state_d = cs_ok ? SORT : IDLE;
            err_d   = !cs_ok;
            cnt_d   = '0;
            pass_d  = '0;
          end
        end else if (tmo_q == TW'(TIMEOUT_CYC - 1)) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      SORT: begin
        mem_d   = net;
        pass_d  = pass_q + 1'b1;
        state_d = (pass_q == PW'(DEPTH - 1)) ? SEND : SORT;
      end
      SEND: begin
        tx_data = byte_out;
        if (!tx_busy) begin
          tx_start = 1'b1;
          state_d  = WAIT_TX;
          first_d  = 1'b1;
          cnt_d    = cnt_q + 1'b1;
          mem_d    = {mem_q[BITS-9:0], 8'h00};
        end
      end
      WAIT_TX:
        if (!first_q && !tx_busy) begin
          state_d = (cnt_q == CW'(LEN)) ? IDLE : SEND;
          fcnt_d  = (cnt_q == CW'(LEN)) ? fcnt_q + 1'b1 : fcnt_q;
        end
      default: state_d = IDLE;
    endcase
  end

  // control registers; element storage is deliberately kept out of reset
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pass_q  <= '0;
      tmo_q   <= '0;
      desc_q  <= 1'b0;
      first_q <= 1'b0;
      err_q   <= 1'b0;
      fcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pass_q  <= pass_d;
      tmo_q   <= tmo_d;
      desc_q  <= desc_d;
      first_q <= first_d;
      err_q   <= err_d;
      fcnt_q  <= fcnt_d;
    end

  // element storage
  always_ff @(posedge clk) mem_q <= mem_d;

  assign busy        = state_q != IDLE;
  assign frame_err   = err_q;
  assign frame_count = fcnt_q;
endmodule

// File: tb/tb_uart_frame_sorter.sv
// tb_uart_frame_sorter: directed frames checked against a queue-sort model of the sorter
module tb_uart_frame_sorter;
  localparam int WIDTH = 32;
  localparam int DEPTH = 8;
  localparam int TMO   = 40;
  localparam int NB    = DEPTH * WIDTH / 8;
`ifdef UART_SORT_CHECKSUM_EN
  localparam int LEN = NB + 1;
`else
  localparam int LEN = NB;
`endif

  logic        clk = 1'b0;
  logic        rst, rx_valid, tx_busy, tx_start, busy, frame_err;
  logic [7:0]  rx_data, tx_data;
  logic [15:0] frame_count;

  int checks = 0, failures = 0, cyc = 0, errs = 0, starts = 0;
  int busy_len = 0, left = 0, t_last = 0, t_first = -1;
  bit pend = 0;
  logic [7:0] exp_q[$], got_q[$];

  logic [WIDTH-1:0] E1[DEPTH]    = '{32'd7, 32'd3, 32'd9, 32'd1, 32'd1, 32'd0, 32'hFFFFFFFF, 32'd2};
  logic [WIDTH-1:0] E1_ASC[DEPTH]  = '{32'd0, 32'd1, 32'd1, 32'd2, 32'd3, 32'd7, 32'd9, 32'hFFFFFFFF};
  logic [WIDTH-1:0] E1_DESC[DEPTH] = '{32'hFFFFFFFF, 32'd9, 32'd7, 32'd3, 32'd2, 32'd1, 32'd1, 32'd0};
  logic [WIDTH-1:0] E2[DEPTH]    = '{32'h12345678, 32'h80000000, 32'h7FFFFFFF, 32'd5,
                                     32'h00FF00FF, 32'd5, 32'hDEADBEEF, 32'd1};
  logic [WIDTH-1:0] E2_ASC[DEPTH]  = '{32'd1, 32'd5, 32'd5, 32'h00FF00FF,
                                       32'h12345678, 32'h7FFFFFFF, 32'h80000000, 32'hDEADBEEF};
  logic [WIDTH-1:0] E2_DESC[DEPTH] = '{32'hDEADBEEF, 32'h80000000, 32'h7FFFFFFF, 32'h12345678,
                                       32'h00FF00FF, 32'd5, 32'd5, 32'd1};

  uart_frame_sorter #(.WIDTH(WIDTH), .DEPTH(DEPTH), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid), .tx_busy(tx_busy),
    .tx_data(tx_data), .tx_start(tx_start), .busy(busy), .frame_err(frame_err),
    .frame_count(frame_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // compare process: every transmitted byte must be the next byte the model predicts
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      if (frame_err) errs++;
      if (tx_start) begin
        starts++;
        if (t_first < 0) t_first = cyc;
        chk("tx_start_while_busy", tx_busy, 0);
        if (exp_q.size() == 0) chk("unexpected_tx_start", 1, 0);
        else chk("tx_byte", tx_data, exp_q.pop_front());
        got_q.push_back(tx_data);
        pend = 1;
      end
    end
  end

  // transmitter model: busy for busy_len cycles after each launched byte
  initial begin
    tx_busy = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (pend) begin pend = 0; left = busy_len; end
      else if (left > 0) left--;
      tx_busy = left > 0;
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1);
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic rx_byte(input logic [7:0] b);
    @(posedge clk); #1;
    rx_data = b; rx_valid = 1'b1; t_last = cyc;
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  // model: sort the elements with the language sort, serialise MSB-byte first, append XOR if enabled
  task automatic send_frame(input logic [7:0] hdr, input logic [WIDTH-1:0] e[DEPTH],
                            input int gap_at, input bit bad);
    logic [WIDTH-1:0] q[$];
    logic [7:0] x, cs, b;
    for (int i = 0; i < DEPTH; i++) q.push_back(e[i]);
    if (hdr == 8'h5A) q.rsort(); else q.sort();
    x = 8'h00;
    if (!bad) begin
      foreach (q[i])
        for (int j = WIDTH/8 - 1; j >= 0; j--) begin
          exp_q.push_back(q[i][j*8 +: 8]);
          x ^= q[i][j*8 +: 8];
        end
`ifdef UART_SORT_CHECKSUM_EN
      exp_q.push_back(x);
`endif
    end
    cs = hdr;
    rx_byte(hdr);
    for (int i = 0; i < DEPTH; i++)
      for (int j = WIDTH/8 - 1; j >= 0; j--) begin
        b = e[i][j*8 +: 8];
        cs ^= b;
        if (i * (WIDTH/8) + (WIDTH/8 - 1 - j) == gap_at) idle(TMO - 2);
        rx_byte(b);
      end
`ifdef UART_SORT_CHECKSUM_EN
    rx_byte(bad ? ~cs : cs);
`endif
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while ((busy || exp_q.size() != 0) && n < 20000) begin @(posedge clk); n++; end
    #1;
    chk({name, "_completed"}, n < 20000, 1);
  endtask

  task automatic check_out(input string name, input logic [WIDTH-1:0] lit[DEPTH]);
    logic [WIDTH-1:0] v;
    chk({name, "_byte_count"}, got_q.size(), LEN);
    if (got_q.size() >= NB)
      for (int i = 0; i < DEPTH; i++) begin
        v = '0;
        for (int j = 0; j < WIDTH/8; j++) v = {v[WIDTH-9:0], got_q[i*(WIDTH/8) + j]};
        chk($sformatf("%s_elem%0d", name, i), v, lit[i]);
      end
  endtask

  initial begin
    int e0, s0, n;
    logic [7:0] x;
    rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00;
    repeat (3) @(posedge clk); #1;
    chk("rst_tx_data", tx_data, 0);
    chk("rst_tx_start", tx_start, 0);
    chk("rst_busy", busy, 0);
    chk("rst_frame_err", frame_err, 0);
    chk("rst_frame_count", frame_count, 0);
    rst = 1'b0;

    got_q.delete(); t_first = -1; e0 = errs;
    send_frame(8'hA5, E1, -1, 0);
    wait_idle("asc");
    chk("asc_latency", t_first - t_last, DEPTH + 1);
    check_out("asc", E1_ASC);
    chk("asc_frame_count", frame_count, 1);
    chk("asc_no_err", errs - e0, 0);

    got_q.delete(); e0 = errs;
    send_frame(8'h5A, E1, -1, 0);
    wait_idle("desc");
    check_out("desc", E1_DESC);
    chk("desc_frame_count", frame_count, 2);
    chk("desc_no_err", errs - e0, 0);

    got_q.delete(); busy_len = 100; s0 = starts;
    send_frame(8'hA5, E2, -1, 0);
    wait_idle("slow_tx");
    chk("slow_tx_starts", starts - s0, LEN);
    check_out("slow_tx", E2_ASC);
    chk("slow_tx_frame_count", frame_count, 3);
    busy_len = 0;
    idle(2);

    e0 = errs; s0 = starts;
    rx_byte(8'hA5);
    for (int i = 0; i < 5; i++) rx_byte(8'(i + 1));
    idle(TMO + 10); #1;
    chk("timeout_err", errs - e0, 1);
    chk("timeout_busy", busy, 0);
    chk("timeout_no_tx", starts - s0, 0);
    chk("timeout_frame_count", frame_count, 3);

    got_q.delete(); e0 = errs;
    send_frame(8'hA5, E2, 10, 0);
    wait_idle("max_gap");
    check_out("max_gap", E2_ASC);
    chk("max_gap_no_err", errs - e0, 0);
    chk("max_gap_frame_count", frame_count, 4);

    e0 = errs; s0 = starts;
    rx_byte(8'h00); rx_byte(8'h3C); rx_byte(8'hFF);
    idle(2); #1;
    chk("junk_busy", busy, 0);
    chk("junk_no_err", errs - e0, 0);
    chk("junk_no_tx", starts - s0, 0);

    got_q.delete(); e0 = errs;
    send_frame(8'h5A, E2, -1, 0);
    rx_byte(8'hA5);
    wait_idle("overrun");
    chk("overrun_err", errs - e0, 1);
    check_out("overrun", E2_DESC);
    chk("overrun_frame_count", frame_count, 5);

    busy_len = 20; s0 = starts; n = 0;
    send_frame(8'hA5, E1, -1, 0);
    while (starts < s0 + 3 && n < 5000) begin @(posedge clk); n++; end
    chk("mid_send_reached", n < 5000, 1);
    #3 rst = 1'b1;
    #1;
    chk("midrst_tx_data", tx_data, 0);
    chk("midrst_tx_start", tx_start, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_frame_err", frame_err, 0);
    chk("midrst_frame_count", frame_count, 0);
    exp_q.delete(); got_q.delete(); pend = 0; left = 0; busy_len = 0;
    @(posedge clk); #1 rst = 1'b0;
    e0 = errs;
    send_frame(8'hA5, E2, -1, 0);
    wait_idle("after_rst");
    check_out("after_rst", E2_ASC);
    chk("after_rst_frame_count", frame_count, 1);
    chk("after_rst_no_err", errs - e0, 0);

`ifdef UART_SORT_CHECKSUM_EN
    e0 = errs; s0 = starts;
    send_frame(8'hA5, E1, -1, 1);
    idle(DEPTH + 6); #1;
    chk("bad_csum_err", errs - e0, 1);
    chk("bad_csum_no_tx", starts - s0, 0);
    chk("bad_csum_busy", busy, 0);
    got_q.delete();
    send_frame(8'h5A, E1, -1, 0);
    wait_idle("csum");
    check_out("csum", E1_DESC);
    x = 8'h00;
    for (int i = 0; i < NB && i < got_q.size(); i++) x ^= got_q[i];
    if (got_q.size() == LEN) chk("csum_trailer", got_q[NB], x);
    chk("csum_frame_count", frame_count, 2);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/uart_frame_sorter.md
UART_FRAME_SORTER -- requirements
Module: uart_frame_sorter

Interface
REQ-001 Parameter WIDTH, default 32, is the bit width of each unsigned element and SHALL be a multiple of 8 and at least 8.
REQ-002 Parameter DEPTH, default 8, is the number of elements per frame and SHALL be at least 2.
REQ-003 Parameter TIMEOUT_CYC, default 1_000_000, is the maximum allowed gap in clocks between consecutive received bytes of one frame.
REQ-004 clk  input  1  single clock, all logic rising-edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 rx_data  input  8  received byte from the UART receiver.
REQ-007 rx_valid  input  1  one-cycle strobe, rx_data valid.
REQ-008 tx_busy  input  1  UART transmitter busy.
REQ-009 tx_data  output  8  byte to transmit.
REQ-010 tx_start  output  1  one-cycle strobe, launch tx_data.
REQ-011 busy  output  1  high in every state except IDLE.
REQ-012 frame_err  output  1  one-cycle pulse on timeout, overrun or checksum failure.
REQ-013 frame_count  output  16  count of frames fully transmitted.

Function
REQ-014 Frame format SHALL be one header byte, then NBYTES = DEPTH*WIDTH/8 data bytes, element 0 first, each element MSB-byte first.
REQ-015 Header 8'hA5 SHALL select ascending order; header 8'h5A SHALL select descending order; any other byte in IDLE SHALL be ignored.
REQ-016 FSM states: IDLE, RECV, SORT, SEND, WAIT_TX.
REQ-017 IDLE->RECV on a valid header; RECV->SORT on the last data byte; SORT->SEND after DEPTH sort cycles; SEND->WAIT_TX on each tx_start; WAIT_TX->SEND when tx_busy is low and bytes remain; WAIT_TX->IDLE after the last byte.
REQ-018 SORT SHALL be odd-even transposition sort, one pass per cycle: even passes compare pairs (0,1),(2,3)...; odd passes compare pairs (1,2),(3,4)...
REQ-019 Comparison SHALL be unsigned with a strict inequality, so equal elements are never swapped.
REQ-020 Latency from the last received byte to the first tx_start SHALL be DEPTH+1 cycles when tx_busy is low.
REQ-021 In SEND, tx_start SHALL pulse for exactly one cycle, and only when tx_busy is low.
REQ-022 WAIT_TX SHALL ignore tx_busy during its first cycle, then wait for tx_busy to be low.
REQ-023 Output byte order SHALL match the input byte order (sorted element 0 first, MSB-byte first); no header byte is echoed.
REQ-024 In RECV, if TIMEOUT_CYC cycles pass with no rx_valid, the block SHALL pulse frame_err, discard the frame and return to IDLE.
REQ-025 rx_valid in SORT, SEND or WAIT_TX SHALL be dropped and SHALL pulse frame_err; the frame in progress continues unaffected.
REQ-026 frame_count SHALL increment on the transition WAIT_TX->IDLE and wrap from 16'hFFFF to 0.

Reset
REQ-027 Asserting rst at any time, including mid-frame, SHALL immediately force IDLE with tx_data=0, tx_start=0, busy=0, frame_err=0, frame_count=0 and all counters cleared.
REQ-028 Element storage need not be cleared on reset.

Configuration
REQ-029 With UART_SORT_CHECKSUM_EN defined, each input frame SHALL carry one trailing byte equal to the XOR of the header and all data bytes.
REQ-030 With UART_SORT_CHECKSUM_EN defined, a checksum mismatch SHALL pulse frame_err and return to IDLE without sorting or transmitting.
REQ-031 With UART_SORT_CHECKSUM_EN defined, the output frame SHALL append one byte equal to the XOR of all transmitted data bytes.
REQ-032 Without UART_SORT_CHECKSUM_EN, no checksum byte SHALL be expected on input or generated on output.

Structure
REQ-033 Package uart_sort_pkg SHALL hold the state enum, the HDR_ASC and HDR_DESC constants, and the NBYTES calculation function.
REQ-034 A single sub-module, sort_cmp_swap (compare-and-swap one element pair, with direction input), SHALL be instantiated once per pair position.

Verification
REQ-035 Scenario: DEPTH=8, header A5, elements 7,3,9,1,1,0,FFFFFFFF,2 -> output 0,1,1,2,3,7,9,FFFFFFFF, frame_count=1.
REQ-036 Scenario: same data with header 5A -> output FFFFFFFF,9,7,3,2,1,1,0.
REQ-037 Scenario: header A5, 5 data bytes, then silence for TIMEOUT_CYC cycles -> one frame_err pulse, busy=0, no tx_start.
REQ-038 Scenario: tx_busy held high for 100 cycles after each start -> exactly NBYTES tx_start pulses, each issued only while tx_busy is low.
REQ-039 Scenario: rst asserted mid-SEND, then a new valid frame -> outputs return to reset values at once, and the new frame sorts and transmits correctly.
REQ-040 Scenario: with UART_SORT_CHECKSUM_EN, a corrupted checksum byte -> frame_err pulse and no tx_start; a correct checksum byte -> output ends with the XOR of the transmitted data bytes.
